// File: rtl/mem_arbiter.sv
// Memory-side arbiter between icache, dcache and one RAM port.
// The grant is held in a registered FSM (IDLE / GNT_D / GNT_I). The RAM-side
// and cache-side outputs are decoded from that state and the live request
// lines, so a withdrawn request drops the RAM enables in the same cycle.
// dcache has priority and its 2-word blocks are locked together. A starvation
// counter guarantees that instruction fetch still makes progress.
// Optional feature macro: MEM_ARB_PERF_EN adds the transfer/stall counters
// d_xfers, i_xfers and i_stall_cyc.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int BURST_LEN    = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] d_xfers,
  output logic [31:0] i_xfers,
  output logic [31:0] i_stall_cyc
`endif
);

  localparam int BEAT_W   = $clog2(BURST_LEN + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;

  state_t              state, state_nx;
  logic [BEAT_W-1:0]   beat, beat_nx;
  logic [STARVE_W-1:0] starve, starve_nx;

  logic d_req, d_done, i_done, starved;

  assign d_req   = dREN | dWEN;
  assign d_done  = (state == GNT_D) && d_req && (ramstate == RAM_ACCESS);
  assign i_done  = (state == GNT_I) && iREN  && (ramstate == RAM_ACCESS);
  assign starved = (int'(starve) == STARVE_LIMIT);

  // Priority pick: starved icache first, then dcache, then icache.
  function automatic state_t pick(input logic starve_hit, input logic i_req,
                                  input logic dc_req);
    state_t s;
    if (starve_hit && i_req) s = GNT_I;
    else if (dc_req)         s = GNT_D;
    else if (i_req)          s = GNT_I;
    else                     s = IDLE;
    return s;
  endfunction

  // Next grant, burst beat count and starvation count.
  always_comb begin
    state_nx  = state;
    beat_nx   = beat;
    starve_nx = starve;
    case (state)
      IDLE: state_nx = pick(starved, iREN, d_req);
      GNT_D: begin
        if (!d_req) begin
          state_nx = IDLE;
          beat_nx  = '0;
        end else if (d_done) begin
          if ((int'(beat) + 1) < BURST_LEN) begin
            beat_nx = beat + 1'b1;
          end else begin
            beat_nx  = '0;
            state_nx = pick(starved, iREN, d_req);
          end
        end
      end
      GNT_I: begin
        if (!iREN)       state_nx = IDLE;
        else if (i_done) state_nx = pick(starved, iREN, d_req);
      end
      default: state_nx = IDLE;
    endcase
    if ((state_nx == GNT_I) && (state != GNT_I))
      starve_nx = '0;
    else if (iREN && (state != GNT_I) && !starved)
      starve_nx = starve + 1'b1;
  end

  // Grant state and counters; reset returns to IDLE with counts cleared.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      beat   <= '0;
      starve <= '0;
    end else begin
      state  <= state_nx;
      beat   <= beat_nx;
      starve <= starve_nx;
    end
  end

  // Route the granted cache onto the RAM port and decode the waits.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state)
      GNT_D: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = !d_done;
      end
      GNT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = !i_done;
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;

`ifdef MEM_ARB_PERF_EN
  // Completed beats per side and icache stall cycles, wrapping mod 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      d_xfers     <= '0;
      i_xfers     <= '0;
      i_stall_cyc <= '0;
    end else begin
      if (d_done)        d_xfers     <= d_xfers + 32'd1;
      if (i_done)        i_xfers     <= i_xfers + 32'd1;
      if (iREN && iwait) i_stall_cyc <= i_stall_cyc + 32'd1;
    end
  end
`endif

endmodule
